// File: rtl/reg_scan_pkg.sv
// rtl/reg_scan_pkg.sv - shared state type and width helpers for the register scan checker
package reg_scan_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    SCAN  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when the register file splits into whole lane groups.
  function automatic bit lanes_divide(input int nregs, input int lanes);
    return (lanes > 0) && ((nregs % lanes) == 0);
  endfunction

endpackage

// File: rtl/reg_scan_lane.sv
// rtl/reg_scan_lane.sv - one scan lane: captured read data plus masked compare
module reg_scan_lane
  import reg_scan_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_scan_data,
  input  logic [DATA_W-1:0] i_exp_data,
  input  logic              i_exp_mask,
  input  logic              i_valid,
  output logic              o_mismatch,
  output logic [DATA_W-1:0] o_act
);

  logic [DATA_W-1:0] r_act;

  // Capture the regfile read so it lines up with the one-cycle ROM latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_act <= '0;
    end else if (i_load) begin
      r_act <= i_scan_data;
    end
  end

  assign o_act      = r_act;
  assign o_mismatch = i_valid && i_exp_mask && (i_exp_data != r_act);

endmodule

// File: rtl/reg_scan_checker.sv
// rtl/reg_scan_checker.sv - gates the processor, scans the regfile and checks it against a ROM
module reg_scan_checker
  import reg_scan_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int LANES  = 1,
  parameter int CYC_W  = 16,
  parameter int ADDR_W = idx_width(NREGS),
  parameter int GRP_W  = idx_width(NREGS / LANES)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CYC_W-1:0]        num_cycles,
  output logic                    cpu_run,
  output logic                    test_mode,
  output logic [LANES*ADDR_W-1:0] scan_addr,
  input  logic [LANES*DATA_W-1:0] scan_data,
  output logic [GRP_W-1:0]        exp_addr,
  input  logic [LANES*DATA_W-1:0] exp_data,
  input  logic [LANES-1:0]        exp_mask,
  input  logic                    cm_we,
  input  logic [ADDR_W-1:0]       cm_rd,
  output logic [CYC_W-1:0]        write_count,
  output logic                    done,
  output logic                    pass,
  output logic [ADDR_W:0]         err_count,
  output logic                    first_err_valid,
  output logic [ADDR_W-1:0]       first_err_reg,
  output logic [DATA_W-1:0]       first_err_exp,
  output logic [DATA_W-1:0]       first_err_act
);

  localparam int              NGRP     = NREGS / LANES;
  localparam int              CNT_W    = ADDR_W + 1;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NGRP - 1);

  if (!lanes_divide(NREGS, LANES)) begin : g_bad_lanes
    $error("reg_scan_checker: NREGS must be a multiple of LANES");
  end

  state_e            r_state;
  state_e            w_next;
  logic              w_start_ok;
  logic              w_cpu_run;
  logic              w_test_mode;
  logic              w_done;
  logic              w_scanning;
  logic [CYC_W-1:0]  r_cnt;
  logic [GRP_W-1:0]  r_grp;
  logic [GRP_W-1:0]  r_cmp_grp;
  logic              r_cmp_vld;
  logic [CYC_W-1:0]  r_wc;
  logic [CNT_W-1:0]  r_err;
  logic              r_fev;
  logic [ADDR_W-1:0] r_freg;
  logic [DATA_W-1:0] r_fexp;
  logic [DATA_W-1:0] r_fact;
  logic [LANES-1:0]  w_mis;
  logic [DATA_W-1:0] w_act [LANES];
  logic [CNT_W-1:0]  w_pop;
  logic              w_hit;
  logic [ADDR_W-1:0] w_hit_reg;
  logic [DATA_W-1:0] w_hit_exp;
  logic [DATA_W-1:0] w_hit_act;

  // Start is honoured only when no check is in flight.
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    w_next      = r_state;
    w_cpu_run   = 1'b0;
    w_test_mode = 1'b0;
    w_done      = 1'b0;
    w_scanning  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = (num_cycles == '0) ? SCAN : RUN;
      end
      RUN: begin
        w_cpu_run = 1'b1;
        if (r_cnt == CYC_W'(1)) w_next = SCAN;
      end
      SCAN: begin
        w_test_mode = 1'b1;
        w_scanning  = 1'b1;
        if (r_grp == LAST_GRP) w_next = CHECK;
      end
      CHECK: begin
        w_test_mode = 1'b1;
        w_next      = DONE;
      end
      DONE: begin
        w_test_mode = 1'b1;
        w_done      = 1'b1;
        if (start) w_next = (num_cycles == '0) ? SCAN : RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  // Run budget countdown, scan group stepping and the compare-stage pipeline tags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_grp     <= '0;
      r_cmp_grp <= '0;
      r_cmp_vld <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_cnt <= num_cycles;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt - CYC_W'(1);
      end
      if (w_start_ok) begin
        r_grp <= '0;
      end else if (w_scanning && (r_grp != LAST_GRP)) begin
        r_grp <= r_grp + GRP_W'(1);
      end
      r_cmp_grp <= r_grp;
      r_cmp_vld <= w_scanning;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign scan_addr[i*ADDR_W +: ADDR_W] =
      w_scanning ? ADDR_W'(int'(r_grp) * LANES + i) : '0;

    reg_scan_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clock       (clock),
      .reset       (reset),
      .i_load      (w_scanning),
      .i_scan_data (scan_data[i*DATA_W +: DATA_W]),
      .i_exp_data  (exp_data[i*DATA_W +: DATA_W]),
      .i_exp_mask  (exp_mask[i]),
      .i_valid     (r_cmp_vld),
      .o_mismatch  (w_mis[i]),
      .o_act       (w_act[i])
    );
  end

  // Mismatch popcount for the group in compare, and the lowest failing lane in it.
  always_comb begin
    w_pop     = '0;
    w_hit     = 1'b0;
    w_hit_reg = '0;
    w_hit_exp = '0;
    w_hit_act = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (w_mis[i]) begin
        w_pop     = w_pop + CNT_W'(1);
        w_hit     = 1'b1;
        w_hit_reg = ADDR_W'(int'(r_cmp_grp) * LANES + i);
        w_hit_exp = exp_data[i*DATA_W +: DATA_W];
        w_hit_act = w_act[i];
      end
    end
  end

  // Error count, first-failure record and commit counter; all cleared by an accepted start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wc   <= '0;
      r_err  <= '0;
      r_fev  <= 1'b0;
      r_freg <= '0;
      r_fexp <= '0;
      r_fact <= '0;
    end else if (w_start_ok) begin
      r_wc   <= '0;
      r_err  <= '0;
      r_fev  <= 1'b0;
      r_freg <= '0;
      r_fexp <= '0;
      r_fact <= '0;
    end else begin
      if (w_cpu_run && cm_we && (cm_rd != '0) && (r_wc != '1)) begin
        r_wc <= r_wc + CYC_W'(1);
      end
      if (r_cmp_vld) begin
        r_err <= r_err + w_pop;
      end
      if (w_hit && !r_fev) begin
        r_fev  <= 1'b1;
        r_freg <= w_hit_reg;
        r_fexp <= w_hit_exp;
        r_fact <= w_hit_act;
      end
    end
  end

  assign cpu_run         = w_cpu_run;
  assign test_mode       = w_test_mode;
  assign exp_addr        = w_scanning ? r_grp : '0;
  assign write_count     = r_wc;
  assign done            = w_done;
  assign pass            = w_done && (r_err == '0);
  assign err_count       = r_err;
  assign first_err_valid = r_fev;
  assign first_err_reg   = r_freg;
  assign first_err_exp   = r_fexp;
  assign first_err_act   = r_fact;

endmodule

// File: tb/tb_reg_scan_checker.sv
// tb/tb_reg_scan_checker.sv - self-checking bench for reg_scan_checker with one and two lanes
module tb_reg_scan_checker;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int CYC_W  = 16;
  localparam int ADDR_W = 5;
  localparam int G1     = 32;
  localparam int G2     = 16;

  logic              clock;
  logic              reset;
  logic              start;
  logic [CYC_W-1:0]  num_cycles;
  logic              cm_we;
  logic [ADDR_W-1:0] cm_rd;

  logic [DATA_W-1:0] rf  [NREGS];
  logic [DATA_W-1:0] rom [NREGS];
  logic              msk [NREGS];

  logic              cpu_run1, test_mode1, done1, pass1, fev1;
  logic [4:0]        scan_addr1, exp_addr1, fer1;
  logic [31:0]       scan_data1, exp_data1, fexp1, fact1;
  logic              exp_mask1;
  logic [15:0]       wc1;
  logic [5:0]        err1;

  logic              cpu_run2, test_mode2, done2, pass2, fev2;
  logic [9:0]        scan_addr2;
  logic [3:0]        exp_addr2;
  logic [63:0]       scan_data2, exp_data2;
  logic [1:0]        exp_mask2;
  logic [4:0]        fer2;
  logic [31:0]       fexp2, fact2;
  logic [15:0]       wc2;
  logic [5:0]        err2;

  int checks = 0;
  int errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign scan_data1 = rf[scan_addr1];
  assign scan_data2 = {rf[scan_addr2[9:5]], rf[scan_addr2[4:0]]};

  always @(posedge clock) begin
    exp_data1 <= rom[exp_addr1];
    exp_mask1 <= msk[exp_addr1];
    exp_data2 <= {rom[{exp_addr2, 1'b1}], rom[{exp_addr2, 1'b0}]};
    exp_mask2 <= {msk[{exp_addr2, 1'b1}], msk[{exp_addr2, 1'b0}]};
  end

  reg_scan_checker #(.LANES(1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .cpu_run(cpu_run1), .test_mode(test_mode1), .scan_addr(scan_addr1), .scan_data(scan_data1),
    .exp_addr(exp_addr1), .exp_data(exp_data1), .exp_mask(exp_mask1),
    .cm_we(cm_we), .cm_rd(cm_rd), .write_count(wc1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_valid(fev1), .first_err_reg(fer1),
    .first_err_exp(fexp1), .first_err_act(fact1)
  );

  reg_scan_checker #(.LANES(2)) u_dut2 (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .cpu_run(cpu_run2), .test_mode(test_mode2), .scan_addr(scan_addr2), .scan_data(scan_data2),
    .exp_addr(exp_addr2), .exp_data(exp_data2), .exp_mask(exp_mask2),
    .cm_we(cm_we), .cm_rd(cm_rd), .write_count(wc2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_valid(fev2), .first_err_reg(fer2),
    .first_err_exp(fexp2), .first_err_act(fact2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_match();
    for (int r = 0; r < NREGS; r++) begin
      rf[r]  = $urandom;
      rom[r] = rf[r];
      msk[r] = 1'b1;
    end
  endtask

  // Start a check with budget n and follow it for n+40 cycles, then compare
  // timing and results of both instances with the expectation built from rf/rom/msk.
  task automatic run_case(input string tag, input int n, input int cm_mode, input int glitch_k);
    int e_err, e_first, e_wc;
    logic [63:0] e_exp, e_act;
    int d1, d2, t1, t2, cr1, cr2, crf1, crl1;
    e_err = 0; e_first = -1; e_wc = 0;
    for (int r = 0; r < NREGS; r++) begin
      if (msk[r] && (rom[r] !== rf[r])) begin
        e_err++;
        if (e_first < 0) e_first = r;
      end
    end
    e_exp = (e_first < 0) ? 64'd0 : {32'd0, rom[e_first]};
    e_act = (e_first < 0) ? 64'd0 : {32'd0, rf[e_first]};
    d1 = -1; d2 = -1; t1 = -1; t2 = -1; cr1 = 0; cr2 = 0; crf1 = -1; crl1 = -1;
    @(negedge clock);
    start = 1'b1;
    num_cycles = CYC_W'(n);
    @(posedge clock);
    for (int k = 1; k <= n + 40; k++) begin
      @(negedge clock);
      start = (k == glitch_k);
      num_cycles = (k == glitch_k) ? CYC_W'(3) : CYC_W'(n);
      if (cm_mode == 1) begin
        cm_we = (k <= 7) || (k > n);
        cm_rd = (k <= 3) ? ADDR_W'(0) : ADDR_W'(k);
      end else begin
        cm_we = 1'($urandom_range(0, 1));
        cm_rd = ADDR_W'($urandom_range(0, NREGS - 1));
      end
      if (cm_we && (cm_rd != 0) && (k <= n)) e_wc++;
      if (cpu_run1) begin
        cr1++;
        if (crf1 < 0) crf1 = k;
        crl1 = k;
      end
      if (cpu_run2) cr2++;
      if (test_mode1 && t1 < 0) t1 = k;
      if (test_mode2 && t2 < 0) t2 = k;
      if (done1 && d1 < 0) d1 = k;
      if (done2 && d2 < 0) d2 = k;
      @(posedge clock);
    end
    @(negedge clock);
    cm_we = 1'b0;
    chk({tag, " done1_cycle"}, d1, n + G1 + 2);
    chk({tag, " done2_cycle"}, d2, n + G2 + 2);
    chk({tag, " scan1_cycle"}, t1, n + 1);
    chk({tag, " scan2_cycle"}, t2, n + 1);
    chk({tag, " run1_cycles"}, cr1, n);
    chk({tag, " run2_cycles"}, cr2, n);
    chk({tag, " run1_first"}, crf1, (n > 0) ? 1 : -1);
    chk({tag, " run1_last"}, crl1, (n > 0) ? n : -1);
    chk({tag, " done1_held"}, {done1, test_mode1, cpu_run1}, 3'b110);
    chk({tag, " done2_held"}, {done2, test_mode2, cpu_run2}, 3'b110);
    chk({tag, " err1"}, err1, e_err);
    chk({tag, " err2"}, err2, e_err);
    chk({tag, " pass1"}, pass1, e_err == 0);
    chk({tag, " pass2"}, pass2, e_err == 0);
    chk({tag, " fev1"}, fev1, e_err != 0);
    chk({tag, " fev2"}, fev2, e_err != 0);
    chk({tag, " freg1"}, fer1, (e_first < 0) ? 0 : e_first);
    chk({tag, " freg2"}, fer2, (e_first < 0) ? 0 : e_first);
    chk({tag, " fexp1"}, fexp1, e_exp);
    chk({tag, " fexp2"}, fexp2, e_exp);
    chk({tag, " fact1"}, fact1, e_act);
    chk({tag, " fact2"}, fact2, e_act);
    chk({tag, " wc1"}, wc1, e_wc);
    chk({tag, " wc2"}, wc2, e_wc);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    num_cycles = '0;
    cm_we = 1'b0;
    cm_rd = '0;
    set_match();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset outs1", {cpu_run1, test_mode1, done1, pass1, fev1, err1, wc1, fer1}, 64'd0);
    chk("reset outs2", {cpu_run2, test_mode2, done2, pass2, fev2, err2, wc2, fer2}, 64'd0);
    chk("reset addr", {scan_addr1, scan_addr2, exp_addr1, exp_addr2}, 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    set_match();
    run_case("pass", 5, 0, 0);

    set_match();
    rf[7] = 32'h12; rom[7] = 32'h13;
    rom[20] = ~rf[20];
    run_case("two_mis", 5, 0, 0);
    msk[20] = 1'b0;
    run_case("mask", 5, 0, 0);

    set_match();
    rom[6] = rf[6] ^ 32'h1;
    rom[7] = rf[7] ^ 32'h8000_0000;
    run_case("lane_pair", 4, 0, 0);

    set_match();
    rom[0] = rf[0] + 32'd1;
    rom[31] = rf[31] ^ 32'hffff;
    run_case("n_zero", 0, 0, 0);

    set_match();
    run_case("commits", 10, 1, 0);

    set_match();
    rom[12] = rf[12] ^ 32'h40;
    run_case("start_in_scan", 6, 0, 11);

    set_match();
    rom[0] = ~rf[0];
    rom[1] = ~rf[1];
    @(negedge clock);
    start = 1'b1;
    num_cycles = CYC_W'(2);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(posedge clock);
    @(negedge clock);
    chk("mid_scan err1", {test_mode1, err1}, {1'b1, 6'd2});
    chk("mid_scan err2", {test_mode2, err2}, {1'b1, 6'd2});
    reset = 1'b0;
    #1;
    chk("async reset1", {done1, test_mode1, cpu_run1, fev1, err1}, 64'd0);
    chk("async reset2", {done2, test_mode2, cpu_run2, fev2, err2}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("post reset idle", {cpu_run1, test_mode1, cpu_run2, test_mode2}, 64'd0);
    run_case("after_reset", 3, 0, 0);

    for (int it = 0; it < 4; it++) begin
      for (int r = 0; r < NREGS; r++) begin
        rf[r]  = $urandom;
        rom[r] = ($urandom_range(0, 3) == 0) ? (rf[r] ^ (32'h1 << $urandom_range(0, 31))) : rf[r];
        msk[r] = ($urandom_range(0, 7) != 0);
      end
      run_case($sformatf("rand%0d", it), $urandom_range(0, 20), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scan_checker.md
Name: reg_scan_checker

Overview:
- Synthesizable on-chip successor to the simulation-only register-check harness.
- Gates the processor for a programmed number of cycles, then drives the regfile read port to scan all registers.
- Compares each register against an expected-value memory (ROM) and reports pass/fail, mismatch count and the first failing register.
- Adds LANES parallel read ports, per-register don't-care mask and a commit-write counter.

Parameters:
- DATA_W, 32, register data width.
- NREGS, 32, number of architectural registers.
- LANES, 1, registers compared per scan cycle; NREGS divisible by LANES.
- CYC_W, 16, width of the cycle budget.
- ADDR_W, $clog2(NREGS), register index width.
- GRP_W, max(1,$clog2(NREGS/LANES)), group index width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle start request.
- num_cycles  in  CYC_W  run budget N, sampled with start.
- cpu_run  out  1  processor clock-enable.
- test_mode  out  1  selects scan_addr onto regfile read ports.
- scan_addr  out  LANES*ADDR_W  lane i reads register g*LANES+i.
- scan_data  in  LANES*DATA_W  combinational regfile read data.
- exp_addr  out  GRP_W  expected-ROM group index g.
- exp_data  in  LANES*DATA_W  expected values, 1-cycle read latency.
- exp_mask  in  LANES  compare enable per lane, same latency as exp_data.
- cm_we  in  1  regfile write enable from processor.
- cm_rd  in  ADDR_W  regfile write index from processor.
- write_count  out  CYC_W  commits during RUN, saturating.
- done  out  1  check complete.
- pass  out  1  done && err_count==0.
- err_count  out  ADDR_W+1  number of mismatching registers.
- first_err_valid  out  1  at least one mismatch recorded.
- first_err_reg  out  ADDR_W  lowest-index failing register.
- first_err_exp  out  DATA_W  expected value at first_err_reg.
- first_err_act  out  DATA_W  actual value at first_err_reg.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; counters, pipeline and first_err_* cleared.
- States: IDLE, RUN, SCAN, CHECK, DONE.
- IDLE/DONE + start=1: clear counters and error record, latch N, go to RUN. If N==0, go straight to SCAN.
- start in RUN/SCAN/CHECK is ignored.
- Cycle 0 = the edge that samples start.
- RUN: cpu_run=1 for exactly N cycles (cycles 1..N); test_mode=0. Then go to SCAN.
- write_count increments when cm_we=1 && cm_rd!=0 while cpu_run=1; saturates at all-ones.
- SCAN: cpu_run=0, test_mode=1. Group g steps 0..G-1 (G=NREGS/LANES), one group per cycle.
- SCAN addressing: scan_addr and exp_addr = g driven in the same cycle; scan_data registered at end of that cycle.
- Compare stage: one cycle later, with exp_data/exp_mask, on the registered data.
- Lane i mismatches iff exp_mask[i] && exp!==act.
- After g=G-1, enter CHECK for one cycle to flush the final compare, then DONE.
- Timing: with N>0, done rises at cycle N+G+2. With N==0, SCAN starts at cycle 1 and done rises at G+2.
- err_count: adds popcount of mismatching lanes per group; max value NREGS, no overflow.
- first_err_*: captured only while first_err_valid=0. Among lanes in one group, the lowest lane wins.
- Register 0 is scanned and compared like any other register.
- DONE: done=1, test_mode=1 (results remain readable), cpu_run=0. Results held until next start or reset.
- Reset mid-operation: immediate return to reset values. Processor is released from test_mode, but cpu_run stays 0 until the next start.

Decomposition:
- Package reg_scan_pkg: state enum {IDLE,RUN,SCAN,CHECK,DONE}, GRP_W/ADDR_W derivation function, and a compile-time assertion NREGS%LANES==0.
- Sub-module reg_scan_lane: per-lane pipeline register plus masked compare, outputting mismatch and actual value; instantiated LANES times via generate.

Test Plan:
- Pass path: N=5, LANES=1, ROM matches regfile -> cpu_run high cycles 1..5, test_mode from 6, done at cycle 39, pass=1, err_count=0.
- Two mismatches: reg7 actual 0x12 vs expected 0x13, reg20 mismatch -> err_count=2, first_err_reg=7, first_err_exp=0x13, first_err_act=0x12, pass=0.
- Mask: same as the two-mismatch case, but exp_mask=0 for reg20 -> err_count=1, first_err_reg=7.
- LANES=2, N=4: mismatches at reg6 (group3 lane0) and reg7 (group3 lane1) -> done at cycle 4+16+2=22, err_count=2, first_err_reg=6.
- N=0 and commit counting: N=0 -> cpu_run never high, SCAN at cycle 1. Separately, N=10 with 3 commits to rd=0 and 4 to rd!=0 -> write_count=4.
- Robustness:
  - start during SCAN -> ignored.
  - reset low mid-SCAN -> done, test_mode, err_count, first_err_valid all 0 immediately.
  - new start then completes normally.
